instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch-side initiator for the single-cycle RISC-V datapath's instruction memory.
- Owns the program counter and drives the fetch address.
- Pairs each returned word with the PC that produced it, under the memory's one-cycle registered-read timing.
- Handles stall, branch/jump redirect, and illegal fetch addresses; delivers a valid-qualified instruction to decode.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MEM_WORDS, 32, number of 32-bit words in instruction memory; used for range check.
- CNT_WIDTH, 16, width of fetch counter.

Ports:
- clock  input  1  datapath clock, all state on posedge.
- reset  input  1  synchronous, active-high.
- stall  input  1  decode not ready; hold current instruction.
- redirect  input  1  taken branch/jump this cycle.
- redirectTarget  input  32  new PC when redirect=1.
- memInstr  input  32  word from instruction memory (registered, valid one cycle after address sampled).
- memPC  output  32  byte address to instruction memory (combinational from state).
- instrOut  output  32  instruction to decode (equals memInstr).
- pcOut  output  32  PC of instrOut.
- instrValid  output  1  instrOut/pcOut meaningful.
- fetchFault  output  1  illegal fetch address trapped.
- faultPC  output  32  offending address.
- fetchCount  output  CNT_WIDTH  instructions issued since reset.

Behaviour:
- Registers: pc (next address), pcInFlight (address issued last edge), state, faultPC, fetchCount.
- States: IDLE (after reset, nothing in flight), RUN, FAULT.
- Reset (synchronous): pc<=RESET_PC, pcInFlight<=RESET_PC, state<=IDLE, faultPC<=0, fetchCount<=0. Outputs then: instrValid=0, fetchFault=0, pcOut=RESET_PC. Reset mid-stream discards any in-flight word.
- Issue address (combinational memPC), by priority:
  - redirect=1 -> redirectTarget;
  - else state==RUN and stall=1 -> pcInFlight (memory re-reads the same word, output stays stable);
  - else -> pc.
- Address check on memPC: illegal if memPC[1:0]!=0 or (memPC>>2)>=MEM_WORDS.
- Edge with legal issue (not stall-hold, or redirect): pcInFlight<=memPC, pc<=memPC+4 (mod 2^32), state<=RUN, fetchCount+=1 (wraps).
- Edge with stall-hold (RUN, stall=1, redirect=0): pc, pcInFlight and fetchCount unchanged.
- Edge with illegal issue (any state except FAULT, or FAULT with redirect): state<=FAULT, faultPC<=memPC, pc unchanged, no count.
- IDLE ignores stall: it always issues pc, since nothing is held.
- FAULT: instrValid=0, fetchFault=1, memPC=pc (ignored). Stays until redirect to a legal target (-> RUN, normal issue) or reset. Redirect to an illegal target updates faultPC and stays in FAULT.
- Outputs: instrOut=memInstr; pcOut=pcInFlight; instrValid=(state==RUN); fetchFault=(state==FAULT).
- Latency: address issued at edge k yields instrOut/instrValid after edge k; steady state one instruction per cycle.
- Redirect while stalled: redirect wins. The stalled instruction is dropped and the target is valid after the same edge.
- pc+4 overflow past 32'hFFFF_FFFC wraps to 0; that address normally lands in FAULT via the range check first.

Decomposition:
- Shared package riscv_fetch_pkg:
  - fetch_state_t enum {IDLE, RUN, FAULT};
  - PC_STEP=4;
  - INSTR_WIDTH=32;
  - NOP encoding 32'h0000_0013 for bench use.
- One sub-module: fetch_addr_check (combinational; inputs addr and MEM_WORDS parameter; output illegal). Reused later by the data-memory side.

Test Plan:
- Reset then 4 free-running cycles, memory preloaded 0..3 with distinct words -> pcOut 0,4,8,12 with matching instrOut; instrValid=1 from the first edge after reset low; fetchCount=4.
- Stall for 3 cycles while pcOut=8 -> instrOut, pcOut and fetchCount frozen for 3 cycles; pcOut=12 on the cycle after stall drops.
- Redirect to 0x40 while pcOut=8, with stall=1 on the same cycle -> next cycle pcOut=0x40, instrOut=mem[16], then 0x44.
- Redirect to 0x42 -> fetchFault=1, faultPC=0x42, instrValid=0; redirect to 0x10 -> pcOut=0x10, fault clears.
- Sequential fetch to 0x7C (MEM_WORDS=32) -> pcOut 0x7C valid, next cycle FAULT with faultPC=0x80.
- Reset asserted mid-run at pcOut=0x20 -> instrValid=0 while reset high; first edge after release gives pcOut=0; fetchCount restarts at 1.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch side of the single-cycle datapath.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } fetch_state_t;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_addr_check.sv
// Flags a byte address that is misaligned or beyond the end of a word-addressed memory.
module fetch_addr_check
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic [INSTR_WIDTH-1:0] addr,
    output logic                   illegal
);

    logic [31:0] word_idx;

    assign word_idx = {2'b00, addr[31:2]};

    always_comb begin
        illegal = (addr[1:0] != 2'b00) || (word_idx >= MEM_WORDS);
    end

endmodule

// File: rtl/instruction_fetch.sv
// Program counter and fetch sequencing for a memory with one-cycle registered reads;
// pairs each returned word with the address that produced it.
module instruction_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirectTarget,
    input  logic [INSTR_WIDTH-1:0] memInstr,
    output logic [31:0]            memPC,
    output logic [INSTR_WIDTH-1:0] instrOut,
    output logic [31:0]            pcOut,
    output logic                   instrValid,
    output logic                   fetchFault,
    output logic [31:0]            faultPC,
    output logic [CNT_WIDTH-1:0]   fetchCount
);

    fetch_state_t         state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          pc_in_flight_q, pc_in_flight_d;
    logic [31:0]          fault_pc_q, fault_pc_d;
    logic [CNT_WIDTH-1:0] fetch_count_q, fetch_count_d;

    logic issue_illegal;
    logic issue;

    fetch_addr_check #(
        .MEM_WORDS(MEM_WORDS)
    ) u_addr_check (
        .addr   (memPC),
        .illegal(issue_illegal)
    );

    // While stalled in RUN the memory re-reads the held word so instrOut stays stable.
    always_comb begin
        memPC = pc_q;
        if (redirect) begin
            memPC = redirectTarget;
        end else if ((state_q == RUN) && stall) begin
            memPC = pc_in_flight_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pc_in_flight_d = pc_in_flight_q;
        fault_pc_d     = fault_pc_q;
        fetch_count_d  = fetch_count_q;

        unique case (state_q)
            IDLE:    issue = 1'b1;
            RUN:     issue = redirect || !stall;
            FAULT:   issue = redirect;
            default: issue = 1'b0;
        endcase

        if (issue) begin
            if (issue_illegal) begin
                state_d    = FAULT;
                fault_pc_d = memPC;
            end else begin
                state_d        = RUN;
                pc_in_flight_d = memPC;
                pc_d           = memPC + PC_STEP;
                fetch_count_d  = fetch_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            pc_in_flight_q <= RESET_PC;
            fault_pc_q     <= 32'h0;
            fetch_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pc_in_flight_q <= pc_in_flight_d;
            fault_pc_q     <= fault_pc_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign instrOut   = memInstr;
    assign pcOut      = pc_in_flight_q;
    assign instrValid = (state_q == RUN);
    assign fetchFault = (state_q == FAULT);
    assign faultPC    = fault_pc_q;
    assign fetchCount = fetch_count_q;

endmodule
